mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_engine.sv | 179 +++++++++++++++++
 tb/tb_mem_copy_engine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - word-by-word memory copy engine (read/write alternating)
//
// Purpose: copies `length` words from src_addr upward to dst_addr upward over a
// single-port word-addressed memory, one word per two cycles (READ then WRITE).
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   start              copy request, accepted only in IDLE
//   src_addr, dst_addr first source / destination word addresses
//   length             number of words to copy (0 gives an immediate done)
//   abort              ends the transfer in READ/WRITE; current strobe still completes
//   addr, write_data   memory address / write data (0 when idle)
//   mem_read           read strobe; read_data is returned in the same cycle
//   mem_write          write strobe; memory writes at the end of the cycle
//   read_data          memory read data
//   busy               high in READ and WRITE
//   done               one-cycle completion pulse
//   aborted            last transfer ended by abort; cleared on the next accepted start
//   words_done         words written in the current or most recent transfer

module mem_copy_engine #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] src_addr,
    input  logic [DATA_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    output logic [DATA_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  words_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0] ONE_D = DATA_W'(1);
    localparam logic [LEN_W-1:0]  ONE_L = LEN_W'(1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   src_ptr_q, src_ptr_d;
    logic [DATA_W-1:0]   dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [LEN_W-1:0]    words_done_q, words_done_d;
    logic                aborted_q, aborted_d;

    // Bus outputs are registered: they are computed from the next state so
    // that in each state they show the values that state calls for.
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        remaining_d  = remaining_q;
        buf_d        = buf_q;
        words_done_d = words_done_q;
        aborted_d    = aborted_q;

        case (state_q)
            S_IDLE: begin
                // start has priority over abort here; abort is meaningless in IDLE
                if (start) begin
                    src_ptr_d    = src_addr;
                    dst_ptr_d    = dst_addr;
                    remaining_d  = length;
                    words_done_d = '0;
                    aborted_d    = 1'b0;
                    state_d      = (length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                buf_d     = read_data;
                src_ptr_d = src_ptr_q + ONE_D;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                // The write strobe of this cycle is not gated by abort, so the
                // word lands and is counted either way.
                dst_ptr_d    = dst_ptr_q + ONE_D;
                words_done_d = words_done_q + ONE_L;
                remaining_d  = remaining_q - ONE_L;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (remaining_q == ONE_L) begin
                    state_d   = S_DONE;
                end else begin
                    state_d   = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_read_d   = (state_d == S_READ);
        mem_write_d  = (state_d == S_WRITE);
        busy_d       = (state_d == S_READ) || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        addr_d       = '0;
        write_data_d = '0;
        if (state_d == S_READ) begin
            addr_d = src_ptr_d;
        end else if (state_d == S_WRITE) begin
            addr_d       = dst_ptr_d;
            write_data_d = buf_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remaining_q  <= '0;
            buf_q        <= '0;
            words_done_q <= '0;
            aborted_q    <= 1'b0;
            addr_q       <= '0;
            write_data_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            remaining_q  <= remaining_d;
            buf_q        <= buf_d;
            words_done_q <= words_done_d;
            aborted_q    <= aborted_d;
            addr_q       <= addr_d;
            write_data_q <= write_data_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign addr       = addr_q;
    assign write_data = write_data_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - scoreboard testbench for mem_copy_engine

module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] length;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        mem_read;
    logic        mem_write;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] words_done;

    mem_copy_engine #(.DATA_W(32), .LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .abort      (abort),
        .addr       (addr),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .read_data  (read_data),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // 256-word memory indexed by the low address byte: addresses wrap naturally
    logic [31:0] seed    [256];
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        init_mem;

    assign read_data = mem_read ? mem[addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed[i];
        end else if (mem_write) begin
            mem[addr[7:0]] <= write_data;
        end
    end

    typedef struct {
        int          kind;   // 0 read, 1 write, 2 done
        logic [31:0] a;
        logic [31:0] d;
        logic [15:0] wd;
        logic        ab;
        longint      c;
    } exp_t;

    exp_t expq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d,
                        input logic [15:0] wd, input logic ab, input longint c);
        exp_t x;
        x.kind = kind; x.a = a; x.d = d; x.wd = wd; x.ab = ab; x.c = c;
        expq.push_back(x);
    endtask

    // Monitor: invariants every cycle, plus scoreboard pop on each strobe/done
    always @(negedge clk) begin
        exp_t e;
        int   kind_act;
        if (rst === 1'b1) begin
            chk("strobe_exclusive", 64'(mem_read && mem_write), 64'd0);
            chk("busy_vs_state", 64'(busy), 64'(mem_read || mem_write));
            if (!mem_read && !mem_write) begin
                chk("idle_addr", 64'(addr), 64'd0);
                chk("idle_wdata", 64'(write_data), 64'd0);
            end
            if (mem_read || mem_write || done) begin
                kind_act = mem_read ? 0 : (mem_write ? 1 : 2);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output kind=%0d addr=%0h required=none (cycle %0d)",
                             kind_act, addr, cyc);
                end else begin
                    e = expq.pop_front();
                    chk("op_kind", 64'(kind_act), 64'(e.kind));
                    chk("op_cycle", 64'(cyc), 64'(e.c));
                    if (kind_act == 0) begin
                        chk("read_addr", 64'(addr), 64'(e.a));
                    end else if (kind_act == 1) begin
                        chk("write_addr", 64'(addr), 64'(e.a));
                        chk("write_data", 64'(write_data), 64'(e.d));
                    end else begin
                        chk("done_words", 64'(words_done), 64'(e.wd));
                        chk("done_aborted", 64'(aborted), 64'(e.ab));
                    end
                end
            end
        end
    end

    task automatic wait_until(input longint target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    // mode: 0 plain, 1 abort in k-th WRITE (1-based), 2 abort in READ of word k
    // (0-based), 3 abort together with start, 4 extra start pulse mid-transfer
    task automatic run(input logic [31:0] s, input logic [31:0] d, input int n,
                       input int mode, input int k);
        int          nr, nw, dc, t;
        logic        ab;
        longint      e0;
        logic [31:0] sa, da, v;
        if (mode == 1) begin
            nr = k; nw = k; dc = 2 * k; ab = 1'b1;
        end else if (mode == 2) begin
            nr = k + 1; nw = k; dc = 2 * k + 1; ab = 1'b1;
        end else begin
            nr = n; nw = n; dc = 2 * n; ab = 1'b0;
        end
        e0 = cyc + 1;
        // Reference copy: ascending, one word at a time, so overlap behaves as
        // a naive forward copy.
        for (int i = 0; i < nr; i++) begin
            sa = s + 32'(i);
            push(0, sa, 32'h0, 16'h0, 1'b0, e0 + 2 * i);
            if (i < nw) begin
                da = d + 32'(i);
                v  = ref_mem[sa[7:0]];
                ref_mem[da[7:0]] = v;
                push(1, da, v, 16'h0, 1'b0, e0 + 2 * i + 1);
            end
        end
        push(2, 32'h0, 32'h0, 16'(nw), ab, e0 + dc);

        src_addr = s; dst_addr = d; length = 16'(n);
        start = 1'b1;
        abort = (mode == 3);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        src_addr = $urandom; dst_addr = $urandom; length = 16'($urandom);
        chk("accept_words_done", 64'(words_done), 64'd0);
        chk("accept_aborted", 64'(aborted), 64'd0);

        if (mode == 1 || mode == 2) begin
            wait_until((mode == 1) ? e0 + 2 * k - 1 : e0 + 2 * k);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end else if (mode == 4) begin
            wait_until(e0 + 3);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end

        t = 0;
        while (expq.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL transfer_timeout pending=%0d required=0", expq.size());
            expq.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        longint      e0;
        int          n, mode, k;
        logic [31:0] v;

        rst = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0;
        for (int i = 0; i < 256; i++) seed[i] = $urandom;
        seed[0] = 32'h11; seed[1] = 32'h22; seed[2] = 32'h33; seed[3] = 32'h44;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed[i];
        init_mem = 1'b1;

        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_aborted", 64'(aborted), 64'd0);
        chk("rst_words_done", 64'(words_done), 64'd0);
        chk("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_wdata", 64'(write_data), 64'd0);

        @(posedge clk); #1;
        init_mem = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        run(32'd0, 32'd16, 4, 0, 0);                 // directed 4-word copy
        run(32'd5, 32'd40, 0, 0, 0);                 // zero length
        run(32'd0, 32'd64, 8, 1, 3);                 // abort in 3rd WRITE
        run(32'd30, 32'd90, 3, 0, 0);                // aborted clears
        run(32'hFFFF_FFFE, 32'h80, 3, 0, 0);         // source pointer wrap
        run(32'd8, 32'd100, 2, 3, 0);                // abort with start
        run(32'd20, 32'd120, 5, 2, 2);               // abort in READ
        run(32'd40, 32'd140, 4, 4, 0);               // start ignored mid-transfer
        run(32'd10, 32'd12, 6, 0, 0);                // overlapping forward copy

        for (int it = 0; it < 24; it++) begin
            n    = $urandom_range(0, 12);
            mode = (n == 0) ? 0 : $urandom_range(0, 2);
            k    = (mode == 1) ? $urandom_range(1, n) : ((mode == 2) ? $urandom_range(0, n - 1) : 0);
            run($urandom, $urandom, n, mode, k);
        end

        // Reset mid-transfer: only the operations before the reset are expected
        e0 = cyc + 1;
        v  = ref_mem[0];
        push(0, 32'd0, 32'h0, 16'h0, 1'b0, e0);
        push(1, 32'd200, v, 16'h0, 1'b0, e0 + 1);
        push(0, 32'd1, 32'h0, 16'h0, 1'b0, e0 + 2);
        src_addr = 32'd0; dst_addr = 32'd200; length = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_until(e0 + 3);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_strobes", 64'({mem_read, mem_write}), 64'd0);
        chk("midrst_addr", 64'(addr), 64'd0);
        chk("midrst_wdata", 64'(write_data), 64'd0);
        chk("midrst_words_done", 64'(words_done), 64'd0);
        chk("midrst_pending_ops", 64'(expq.size()), 64'd0);
        expq.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        rst = 1'b1;
        run(32'd50, 32'd180, 3, 0, 0);               // accepted on first edge after reset

        for (int i = 0; i < 256; i++) chk("mem_final", 64'(mem[i]), 64'(ref_mem[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
